// File: rtl/soft_jtag_tap_if.sv
// Signal bundle for soft_jtag_tap: JTAG pins (except tck) plus two user DR endpoints.
// master: JTAG host / endpoint side (drives tms, tdi, userN_tdo).
// slave : the TAP controller (drives tdo, tdo_oe, tlr and all userN_* decode outputs).
interface soft_jtag_tap_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;
  logic tlr;

  logic user1_sel;
  logic user1_capture;
  logic user1_shift;
  logic user1_update;
  logic user1_drck;
  logic user1_tdi;
  logic user1_tdo;

  logic user2_sel;
  logic user2_capture;
  logic user2_shift;
  logic user2_update;
  logic user2_drck;
  logic user2_tdi;
  logic user2_tdo;

  modport master (
    output tms, tdi, user1_tdo, user2_tdo,
    input  tdo, tdo_oe, tlr,
    input  user1_sel, user1_capture, user1_shift, user1_update, user1_drck, user1_tdi,
    input  user2_sel, user2_capture, user2_shift, user2_update, user2_drck, user2_tdi
  );

  modport slave (
    input  tms, tdi, user1_tdo, user2_tdo,
    output tdo, tdo_oe, tlr,
    output user1_sel, user1_capture, user1_shift, user1_update, user1_drck, user1_tdi,
    output user2_sel, user2_capture, user2_shift, user2_update, user2_drck, user2_tdi
  );
endinterface

// File: rtl/soft_jtag_tap.sv
// Fabric IEEE 1149.1 TAP controller with IDCODE, BYPASS and two user DR endpoints.
// Ports:
//   tck  - JTAG clock; state and shift registers on rising edge, IR/tdo/drck enables on falling
//   rst  - asynchronous active-high reset (TAP to TEST_LOGIC_RESET, IR to IDCODE)
//   jtag - soft_jtag_tap_if.slave: tms/tdi/tdo/tdo_oe/tlr and user1/user2 endpoint signals
module soft_jtag_tap #(
  parameter int unsigned        IR_LEN     = 6,
  parameter logic [31:0]        IDCODE_VAL = 32'h0000_0001,
  parameter logic [IR_LEN-1:0]  OP_IDCODE  = IR_LEN'('h09),
  parameter logic [IR_LEN-1:0]  OP_USER1   = IR_LEN'('h02),
  parameter logic [IR_LEN-1:0]  OP_USER2   = IR_LEN'('h03)
) (
  input  logic            tck,
  input  logic            rst,
  soft_jtag_tap_if.slave  jtag
);

  typedef enum logic [3:0] {
    StTlr, StRti,
    StSelDr, StCapDr, StShDr, StEx1Dr, StPaDr, StEx2Dr, StUpdDr,
    StSelIr, StCapIr, StShIr, StEx1Ir, StPaIr, StEx2Ir, StUpdIr
  } tap_state_e;

  tap_state_e        state_q, state_d;
  logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
  logic [IR_LEN-1:0] ir_q, ir_d;
  logic [31:0]       idcode_q, idcode_d;
  logic              bypass_q, bypass_d;
  logic              tdo_q, tdo_d;
  logic              tdo_oe_q, tdo_oe_d;
  logic              drck_en1_q, drck_en1_d;
  logic              drck_en2_q, drck_en2_d;

  logic sel1, sel2, sel_idcode, sel_bypass;
  logic in_cap_dr, in_sh_dr;

  assign sel1       = (ir_q == OP_USER1);
  assign sel2       = (ir_q == OP_USER2);
  assign sel_idcode = (ir_q == OP_IDCODE);
  assign sel_bypass = !(sel1 || sel2 || sel_idcode);
  assign in_cap_dr  = (state_q == StCapDr);
  assign in_sh_dr   = (state_q == StShDr);

  // TAP next-state per the 1149.1 TMS table
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = jtag.tms ? StTlr   : StRti;
      StRti:   state_d = jtag.tms ? StSelDr : StRti;
      StSelDr: state_d = jtag.tms ? StSelIr : StCapDr;
      StCapDr: state_d = jtag.tms ? StEx1Dr : StShDr;
      StShDr:  state_d = jtag.tms ? StEx1Dr : StShDr;
      StEx1Dr: state_d = jtag.tms ? StUpdDr : StPaDr;
      StPaDr:  state_d = jtag.tms ? StEx2Dr : StPaDr;
      StEx2Dr: state_d = jtag.tms ? StUpdDr : StShDr;
      StUpdDr: state_d = jtag.tms ? StSelDr : StRti;
      StSelIr: state_d = jtag.tms ? StTlr   : StCapIr;
      StCapIr: state_d = jtag.tms ? StEx1Ir : StShIr;
      StShIr:  state_d = jtag.tms ? StEx1Ir : StShIr;
      StEx1Ir: state_d = jtag.tms ? StUpdIr : StPaIr;
      StPaIr:  state_d = jtag.tms ? StEx2Ir : StPaIr;
      StEx2Ir: state_d = jtag.tms ? StUpdIr : StShIr;
      StUpdIr: state_d = jtag.tms ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  // Rising-edge shift paths
  always_comb begin
    ir_shift_d = ir_shift_q;
    idcode_d   = idcode_q;
    bypass_d   = bypass_q;
    if (state_q == StCapIr) begin
      ir_shift_d = {{(IR_LEN-2){1'b0}}, 2'b01};
    end else if (state_q == StShIr) begin
      ir_shift_d = {jtag.tdi, ir_shift_q[IR_LEN-1:1]};
    end
    if (sel_idcode && in_cap_dr) begin
      idcode_d = IDCODE_VAL;
    end else if (sel_idcode && in_sh_dr) begin
      idcode_d = {jtag.tdi, idcode_q[31:1]};
    end
    if (sel_bypass && in_cap_dr) begin
      bypass_d = 1'b0;
    end else if (sel_bypass && in_sh_dr) begin
      bypass_d = jtag.tdi;
    end
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      state_q    <= StTlr;
      ir_shift_q <= '0;
      idcode_q   <= '0;
      bypass_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_shift_q <= ir_shift_d;
      idcode_q   <= idcode_d;
      bypass_q   <= bypass_d;
    end
  end

  // Falling-edge IR, tdo and drck enables
  always_comb begin
    ir_d       = ir_q;
    tdo_d      = 1'b0;
    tdo_oe_d   = 1'b0;
    drck_en1_d = sel1 && (in_cap_dr || in_sh_dr);
    drck_en2_d = sel2 && (in_cap_dr || in_sh_dr);
    if (state_q == StTlr) begin
      ir_d = OP_IDCODE;
    end else if (state_q == StUpdIr) begin
      ir_d = ir_shift_q;
    end
    if (state_q == StShIr) begin
      tdo_d    = ir_shift_q[0];
      tdo_oe_d = 1'b1;
    end else if (in_sh_dr) begin
      tdo_oe_d = 1'b1;
      if (sel1) begin
        tdo_d = jtag.user1_tdo;
      end else if (sel2) begin
        tdo_d = jtag.user2_tdo;
      end else if (sel_idcode) begin
        tdo_d = idcode_q[0];
      end else begin
        tdo_d = bypass_q;
      end
    end
  end

  always_ff @(negedge tck or posedge rst) begin
    if (rst) begin
      ir_q       <= OP_IDCODE;
      tdo_q      <= 1'b0;
      tdo_oe_q   <= 1'b0;
      drck_en1_q <= 1'b0;
      drck_en2_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      tdo_q      <= tdo_d;
      tdo_oe_q   <= tdo_oe_d;
      drck_en1_q <= drck_en1_d;
      drck_en2_q <= drck_en2_d;
    end
  end

  assign jtag.tdo    = tdo_q;
  assign jtag.tdo_oe = tdo_oe_q;
  assign jtag.tlr    = (state_q == StTlr);

  // Capture/shift/update are BSCAN-style: not qualified by sel
  assign jtag.user1_sel     = sel1;
  assign jtag.user1_capture = in_cap_dr;
  assign jtag.user1_shift   = in_sh_dr;
  assign jtag.user1_update  = (state_q == StUpdDr);
  assign jtag.user1_tdi     = jtag.tdi;
  // Enable only changes while tck is low, so the AND cannot glitch
  assign jtag.user1_drck    = tck & drck_en1_q;

  assign jtag.user2_sel     = sel2;
  assign jtag.user2_capture = in_cap_dr;
  assign jtag.user2_shift   = in_sh_dr;
  assign jtag.user2_update  = (state_q == StUpdDr);
  assign jtag.user2_tdi     = jtag.tdi;
  assign jtag.user2_drck    = tck & drck_en2_q;

endmodule

// File: tb/tb_soft_jtag_tap.sv
module tb_soft_jtag_tap;
  localparam int unsigned IR_LEN = 6;
  localparam logic [31:0] IDV    = 32'h4BA0_0477;

  logic tck;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   d1_cnt, d2_cnt, cap1_cnt, sh1_cnt;

  soft_jtag_tap_if jif ();

  soft_jtag_tap #(
    .IR_LEN    (IR_LEN),
    .IDCODE_VAL(IDV),
    .OP_IDCODE (6'h09),
    .OP_USER1  (6'h02),
    .OP_USER2  (6'h03)
  ) dut (
    .tck (tck),
    .rst (rst),
    .jtag(jif.slave)
  );

  initial tck = 1'b0;
  always #10 tck = ~tck;

  always @(posedge jif.user1_drck) d1_cnt++;
  always @(posedge jif.user2_drck) d2_cnt++;
  always @(negedge tck) begin
    if (jif.user1_capture) cap1_cnt++;
    if (jif.user1_shift) sh1_cnt++;
  end

  // Drive tms/tdi, then pass one full tck cycle; returns just after the falling edge
  task automatic tick(input logic t, input logic d);
    jif.tms = t;
    jif.tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic shift_ir(input logic [IR_LEN-1:0] val, output logic [IR_LEN-1:0] cap);
    tick(1'b1, 1'b0);  // SEL_DR
    tick(1'b1, 1'b0);  // SEL_IR
    tick(1'b0, 1'b0);  // CAP_IR
    tick(1'b0, 1'b0);  // SH_IR
    for (int i = 0; i < int'(IR_LEN); i++) begin
      cap[i] = jif.tdo;
      tick(i == int'(IR_LEN) - 1, val[i]);
    end
    tick(1'b1, 1'b0);  // UPD_IR
    tick(1'b0, 1'b0);  // RTI
  endtask

  // n-bit DR scan from RTI back to RTI; ep is what the endpoint presents on userN_tdo
  task automatic scan_dr(input int n, input logic [31:0] din, input logic [31:0] ep,
                         output logic [31:0] dout, output logic oe_ok, output logic tdi_ok);
    dout   = '0;
    oe_ok  = 1'b1;
    tdi_ok = 1'b1;
    tick(1'b1, 1'b0);  // SEL_DR
    jif.user1_tdo = ep[0];
    jif.user2_tdo = ep[0];
    tick(1'b0, 1'b0);  // CAP_DR
    tick(1'b0, 1'b0);  // SH_DR
    for (int i = 0; i < n; i++) begin
      dout[i] = jif.tdo;
      oe_ok   = oe_ok & jif.tdo_oe;
      if (i < 31) begin
        jif.user1_tdo = ep[i+1];
        jif.user2_tdo = ep[i+1];
      end
      tick(i == n - 1, din[i]);
      if (jif.user1_tdi !== jif.tdi || jif.user2_tdi !== jif.tdi) tdi_ok = 1'b0;
    end
    tick(1'b1, 1'b0);  // UPD_DR
    tick(1'b0, 1'b0);  // RTI
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #25;
    rst = 1'b0;
    @(negedge tck);
    #1;
    tick(1'b0, 1'b0);  // RTI
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    n_cmp++; if (jif.tlr !== 1'b1) begin n_err++; $display("FAIL reset_tlr got %b want 1", jif.tlr); end
    n_cmp++; if (jif.tdo_oe !== 1'b0) begin n_err++; $display("FAIL reset_tdo_oe got %b want 0", jif.tdo_oe); end
    n_cmp++; if (jif.tdo !== 1'b0) begin n_err++; $display("FAIL reset_tdo got %b want 0", jif.tdo); end
    n_cmp++; if (jif.user1_sel !== 1'b0) begin n_err++; $display("FAIL reset_sel1 got %b want 0", jif.user1_sel); end
    n_cmp++; if (jif.user2_sel !== 1'b0) begin n_err++; $display("FAIL reset_sel2 got %b want 0", jif.user2_sel); end
    @(posedge tck);
    #1;
    n_cmp++; if (jif.user1_drck !== 1'b0) begin n_err++; $display("FAIL reset_drck1 got %b want 0", jif.user1_drck); end
    n_cmp++; if (jif.user2_drck !== 1'b0) begin n_err++; $display("FAIL reset_drck2 got %b want 0", jif.user2_drck); end
    @(negedge tck);
    #1;
    tick(1'b0, 1'b0);  // RTI
  endtask

  task automatic test_idcode;
    logic [31:0] dout;
    logic oe_ok, tdi_ok;
    scan_dr(32, 32'hFFFF_0000, 32'h0, dout, oe_ok, tdi_ok);
    n_cmp++; if (dout !== IDV) begin n_err++; $display("FAIL idcode_value got %h want %h", dout, IDV); end
    n_cmp++; if (dout[0] !== 1'b1) begin n_err++; $display("FAIL idcode_bit0 got %b want 1", dout[0]); end
    n_cmp++; if (oe_ok !== 1'b1) begin n_err++; $display("FAIL idcode_oe got %b want 1", oe_ok); end
    n_cmp++; if (jif.tdo_oe !== 1'b0) begin n_err++; $display("FAIL idcode_oe_after got %b want 0", jif.tdo_oe); end
  endtask

  task automatic test_ir_capture;
    logic [IR_LEN-1:0] cap;
    shift_ir(6'h02, cap);
    n_cmp++; if (cap[1:0] !== 2'b01) begin n_err++; $display("FAIL ir_capture got %b want 01", cap[1:0]); end
    n_cmp++; if (cap !== 6'b000001) begin n_err++; $display("FAIL ir_capture_full got %b want 000001", cap); end
    n_cmp++; if (jif.user1_sel !== 1'b1) begin n_err++; $display("FAIL ir_sel1 got %b want 1", jif.user1_sel); end
    n_cmp++; if (jif.user2_sel !== 1'b0) begin n_err++; $display("FAIL ir_sel2 got %b want 0", jif.user2_sel); end
  endtask

  task automatic test_user1;
    logic [31:0] dout;
    logic oe_ok, tdi_ok;
    d1_cnt = 0; d2_cnt = 0; cap1_cnt = 0; sh1_cnt = 0;
    scan_dr(8, 32'hA5, 32'h0000_003C, dout, oe_ok, tdi_ok);
    n_cmp++; if (d1_cnt !== 9) begin n_err++; $display("FAIL user1_drck_edges got %0d want 9", d1_cnt); end
    n_cmp++; if (d2_cnt !== 0) begin n_err++; $display("FAIL user2_drck_edges got %0d want 0", d2_cnt); end
    n_cmp++; if (cap1_cnt !== 1) begin n_err++; $display("FAIL user1_capture_len got %0d want 1", cap1_cnt); end
    n_cmp++; if (sh1_cnt !== 8) begin n_err++; $display("FAIL user1_shift_len got %0d want 8", sh1_cnt); end
    n_cmp++; if (tdi_ok !== 1'b1) begin n_err++; $display("FAIL user1_tdi_pass got %b want 1", tdi_ok); end
    n_cmp++; if (dout[7:0] !== 8'h3C) begin n_err++; $display("FAIL user1_tdo got %h want 3c", dout[7:0]); end
  endtask

  task automatic test_user2_sel;
    logic [IR_LEN-1:0] cap;
    shift_ir(6'h03, cap);
    n_cmp++; if ({jif.user1_sel, jif.user2_sel} !== 2'b01) begin
      n_err++; $display("FAIL user2_sel got %b want 01", {jif.user1_sel, jif.user2_sel});
    end
  endtask

  task automatic test_bypass;
    logic [IR_LEN-1:0] cap;
    logic [31:0] dout;
    logic oe_ok, tdi_ok;
    shift_ir(6'h3F, cap);
    n_cmp++; if ({jif.user1_sel, jif.user2_sel} !== 2'b00) begin
      n_err++; $display("FAIL bypass_sel got %b want 00", {jif.user1_sel, jif.user2_sel});
    end
    // tdi time order 1,0,1,1,0; tdo = 0 then tdi delayed one tck
    scan_dr(5, 32'h0000_000D, 32'hFFFF_FFFF, dout, oe_ok, tdi_ok);
    n_cmp++; if (dout[4:0] !== 5'b11010) begin n_err++; $display("FAIL bypass_stream got %b want 11010", dout[4:0]); end
  endtask

  task automatic test_tms_reset;
    logic [IR_LEN-1:0] cap;
    shift_ir(6'h02, cap);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    n_cmp++; if (jif.tlr !== 1'b1) begin n_err++; $display("FAIL tms_reset_tlr got %b want 1", jif.tlr); end
    n_cmp++; if (jif.user1_sel !== 1'b0) begin n_err++; $display("FAIL tms_reset_sel1 got %b want 0", jif.user1_sel); end
    tick(1'b0, 1'b0);  // RTI
  endtask

  task automatic test_async_reset;
    logic [IR_LEN-1:0] cap;
    logic [31:0] dout;
    logic oe_ok, tdi_ok;
    int d1_before;
    shift_ir(6'h02, cap);
    tick(1'b1, 1'b0);  // SEL_DR
    tick(1'b0, 1'b0);  // CAP_DR
    tick(1'b0, 1'b0);  // SH_DR
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    rst = 1'b1;  // tck is low here
    #1;
    d1_before = d1_cnt;
    n_cmp++; if (jif.tlr !== 1'b1) begin n_err++; $display("FAIL arst_tlr got %b want 1", jif.tlr); end
    n_cmp++; if (jif.user1_sel !== 1'b0) begin n_err++; $display("FAIL arst_sel1 got %b want 0", jif.user1_sel); end
    n_cmp++; if (jif.tdo_oe !== 1'b0) begin n_err++; $display("FAIL arst_tdo_oe got %b want 0", jif.tdo_oe); end
    @(posedge tck);
    #1;
    n_cmp++; if (jif.user1_drck !== 1'b0) begin n_err++; $display("FAIL arst_drck got %b want 0", jif.user1_drck); end
    @(negedge tck);
    #1;
    n_cmp++; if (d1_cnt !== d1_before) begin n_err++; $display("FAIL arst_runt got %0d want %0d", d1_cnt, d1_before); end
    rst = 1'b0;
    tick(1'b0, 1'b0);  // RTI
    scan_dr(32, 32'h0, 32'h0, dout, oe_ok, tdi_ok);
    n_cmp++; if (dout !== IDV) begin n_err++; $display("FAIL arst_ir_idcode got %h want %h", dout, IDV); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    d1_cnt = 0; d2_cnt = 0; cap1_cnt = 0; sh1_cnt = 0;
    rst = 1'b0;
    jif.tms = 1'b1;
    jif.tdi = 1'b0;
    jif.user1_tdo = 1'b0;
    jif.user2_tdo = 1'b0;
    test_reset();
    test_idcode();
    test_ir_capture();
    test_user1();
    test_user2_sel();
    test_bypass();
    test_tms_reset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end
endmodule
